stats_log_requester: RTL and testbench

STATS_LOG_REQUESTER -- requirements
Module: stats_log_requester

---
 rtl/stats_log_pkg.sv | 48 ++++
 rtl/log_req_flit_gen.sv | 31 +++
 rtl/stats_log_requester.sv | 167 ++++++++++++++++
 tb/tb_stats_log_requester.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stats_log_pkg.sv
// Shared definitions for the stats log requester: NoC widths,
// log request encodings, request flit layout and meta-response offsets.
package stats_log_pkg;

    localparam int NOC_DATA_WIDTH        = 64;
    localparam int STATS_DEPTH_LOG2      = 4;
    localparam int RS_ENC_STATS_STRUCT_W = 32;

    localparam int XY_W             = 8;
    localparam int MSG_TYPE_W       = 8;
    localparam int LOG_ADDR_FIELD_W = 16;
    localparam int LOG_PAD_W        = NOC_DATA_WIDTH - 4 * XY_W
                                      - MSG_TYPE_W - LOG_ADDR_FIELD_W;

    localparam logic [MSG_TYPE_W-1:0] LOG_META_REQ = 8'd20;
    localparam logic [MSG_TYPE_W-1:0] LOG_RD_REQ   = 8'd21;

    // Meta data flit: write pointer in the low bits, wrap flag just above.
    localparam int META_WR_ADDR_LSB = 0;

    function automatic int meta_wrapped_bit(input int addr_w);
        return META_WR_ADDR_LSB + addr_w;
    endfunction

    // Fields listed MSB first; the address is zero-extended into its field.
    typedef struct packed {
        logic [XY_W-1:0]             dst_x;
        logic [XY_W-1:0]             dst_y;
        logic [XY_W-1:0]             src_x;
        logic [XY_W-1:0]             src_y;
        logic [MSG_TYPE_W-1:0]       msg_type;
        logic [LOG_ADDR_FIELD_W-1:0] addr;
        logic [LOG_PAD_W-1:0]        pad;
    } log_req_flit_t;

    typedef enum logic [3:0] {
        IDLE,
        META_REQ,
        META_HDR,
        META_DATA,
        RD_REQ,
        RD_HDR,
        RD_DATA,
        OUT,
        DONE
    } log_req_state_e;

endpackage

// File: rtl/log_req_flit_gen.sv
// Combinational request flit builder: message type + log address -> flit.
// Ports: i_msg_type, i_addr in; o_flit (NOC_DATA_WIDTH) out.
module log_req_flit_gen
    import stats_log_pkg::*;
#(
    parameter int SRC_X  = -1,
    parameter int SRC_Y  = -1,
    parameter int DST_X  = -1,
    parameter int DST_Y  = -1,
    parameter int ADDR_W = STATS_DEPTH_LOG2
) (
    input  logic [MSG_TYPE_W-1:0]     i_msg_type,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic [NOC_DATA_WIDTH-1:0] o_flit
);

    log_req_flit_t w_flit;

    always_comb begin
        w_flit          = '0;
        w_flit.dst_x    = XY_W'(DST_X);
        w_flit.dst_y    = XY_W'(DST_Y);
        w_flit.src_x    = XY_W'(SRC_X);
        w_flit.src_y    = XY_W'(SRC_Y);
        w_flit.msg_type = i_msg_type;
        w_flit.addr     = LOG_ADDR_FIELD_W'(i_addr);
    end

    assign o_flit = w_flit;

endmodule

// File: rtl/stats_log_requester.sv
// Dumps a remote stats log over the NoC: fetches the log metadata, then
// reads entries oldest first, one request outstanding at a time.
// Ports: clk, rst_n; start_val/rdy; NoC request (val/data/rdy);
// NoC response (val/data/rdy); entry_val/data/last/rdy; dump_done.
module stats_log_requester
    import stats_log_pkg::*;
#(
    parameter int SRC_X   = -1,
    parameter int SRC_Y   = -1,
    parameter int DST_X   = -1,
    parameter int DST_Y   = -1,
    parameter int ADDR_W  = STATS_DEPTH_LOG2,
    parameter int ENTRY_W = RS_ENC_STATS_STRUCT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_val,
    output logic                      start_rdy,
    output logic                      req_noc0_vrtoc_val,
    output logic [NOC_DATA_WIDTH-1:0] req_noc0_vrtoc_data,
    input  logic                      noc0_vrtoc_req_rdy,
    input  logic                      noc0_ctovr_resp_val,
    input  logic [NOC_DATA_WIDTH-1:0] noc0_ctovr_resp_data,
    output logic                      resp_noc0_ctovr_rdy,
    output logic                      entry_val,
    output logic [ENTRY_W-1:0]        entry_data,
    output logic                      entry_last,
    input  logic                      entry_rdy,
    output logic                      dump_done
);

    localparam int               LP_WRAP_BIT = meta_wrapped_bit(ADDR_W);
    localparam logic [ADDR_W:0]  LP_FULL     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  LP_ONE      = (ADDR_W+1)'(1);

    log_req_state_e r_state;
    log_req_state_e w_next;

    logic [ADDR_W-1:0]         r_base;
    logic [ADDR_W:0]           r_count;
    logic [ADDR_W:0]           r_idx;
    logic [ENTRY_W-1:0]        r_entry;

    logic [MSG_TYPE_W-1:0]     w_msg_type;
    logic [ADDR_W-1:0]         w_req_addr;
    logic [ADDR_W-1:0]         w_rd_addr;
    logic [NOC_DATA_WIDTH-1:0] w_flit;
    logic [ADDR_W-1:0]         w_meta_wr_addr;
    logic                      w_meta_wrapped;
    logic [ADDR_W:0]           w_meta_count;
    logic [ADDR_W-1:0]         w_meta_base;
    logic                      w_last;
    logic                      w_unused_resp;

    assign w_meta_wr_addr =
        noc0_ctovr_resp_data[META_WR_ADDR_LSB +: ADDR_W];
    assign w_meta_wrapped = noc0_ctovr_resp_data[LP_WRAP_BIT];

    // A wrapped log is full: start at the write pointer, read every slot.
    assign w_meta_count = w_meta_wrapped ? LP_FULL
                                         : {1'b0, w_meta_wr_addr};
    assign w_meta_base  = w_meta_wrapped ? w_meta_wr_addr : '0;

    // Truncation to ADDR_W bits gives the modulo wrap of the ring.
    assign w_rd_addr = r_base + r_idx[ADDR_W-1:0];
    assign w_last    = (r_idx == r_count - LP_ONE);

    assign w_unused_resp = ^noc0_ctovr_resp_data;

    log_req_flit_gen #(
        .SRC_X  (SRC_X),
        .SRC_Y  (SRC_Y),
        .DST_X  (DST_X),
        .DST_Y  (DST_Y),
        .ADDR_W (ADDR_W)
    ) u_flit_gen (
        .i_msg_type (w_msg_type),
        .i_addr     (w_req_addr),
        .o_flit     (w_flit)
    );

    always_comb begin
        w_next              = r_state;
        start_rdy           = 1'b0;
        req_noc0_vrtoc_val  = 1'b0;
        w_msg_type          = LOG_RD_REQ;
        w_req_addr          = w_rd_addr;
        resp_noc0_ctovr_rdy = 1'b0;
        entry_val           = 1'b0;
        entry_last          = 1'b0;
        dump_done           = 1'b0;
        unique case (r_state)
            IDLE: begin
                start_rdy = 1'b1;
                if (start_val) w_next = META_REQ;
            end
            META_REQ: begin
                req_noc0_vrtoc_val = 1'b1;
                w_msg_type         = LOG_META_REQ;
                w_req_addr         = '0;
                if (noc0_vrtoc_req_rdy) w_next = META_HDR;
            end
            META_HDR: begin
                resp_noc0_ctovr_rdy = 1'b1;
                if (noc0_ctovr_resp_val) w_next = META_DATA;
            end
            META_DATA: begin
                resp_noc0_ctovr_rdy = 1'b1;
                if (noc0_ctovr_resp_val) begin
                    w_next = (w_meta_count == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                req_noc0_vrtoc_val = 1'b1;
                if (noc0_vrtoc_req_rdy) w_next = RD_HDR;
            end
            RD_HDR: begin
                resp_noc0_ctovr_rdy = 1'b1;
                if (noc0_ctovr_resp_val) w_next = RD_DATA;
            end
            RD_DATA: begin
                resp_noc0_ctovr_rdy = 1'b1;
                if (noc0_ctovr_resp_val) w_next = OUT;
            end
            OUT: begin
                entry_val  = 1'b1;
                entry_last = w_last;
                if (entry_rdy) w_next = w_last ? DONE : RD_REQ;
            end
            DONE: begin
                dump_done = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Flit is only driven while a request is offered.
    assign req_noc0_vrtoc_data = req_noc0_vrtoc_val ? w_flit : '0;
    assign entry_data          = r_entry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_entry <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start_val) begin
                r_idx <= '0;
            end
            if (r_state == META_DATA && noc0_ctovr_resp_val) begin
                r_base  <= w_meta_base;
                r_count <= w_meta_count;
            end
            if (r_state == RD_DATA && noc0_ctovr_resp_val) begin
                r_entry <= noc0_ctovr_resp_data[ENTRY_W-1:0];
            end
            if (r_state == OUT && entry_rdy) begin
                r_idx <= r_idx + LP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_stats_log_requester.sv
// Directed bench for stats_log_requester: table of dump scenarios
// plus hand-written reset-in-dump and reset-state sequences.
module tb_stats_log_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_val;
    logic        start_rdy;
    logic        req_noc0_vrtoc_val;
    logic [63:0] req_noc0_vrtoc_data;
    logic        noc0_vrtoc_req_rdy;
    logic        noc0_ctovr_resp_val;
    logic [63:0] noc0_ctovr_resp_data;
    logic        resp_noc0_ctovr_rdy;
    logic        entry_val;
    logic [31:0] entry_data;
    logic        entry_last;
    logic        entry_rdy;
    logic        dump_done;

    always #5 clk = ~clk;

    stats_log_requester #(
        .SRC_X (1), .SRC_Y (2), .DST_X (3), .DST_Y (4),
        .ADDR_W (4), .ENTRY_W (32)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_val            (start_val),
        .start_rdy            (start_rdy),
        .req_noc0_vrtoc_val   (req_noc0_vrtoc_val),
        .req_noc0_vrtoc_data  (req_noc0_vrtoc_data),
        .noc0_vrtoc_req_rdy   (noc0_vrtoc_req_rdy),
        .noc0_ctovr_resp_val  (noc0_ctovr_resp_val),
        .noc0_ctovr_resp_data (noc0_ctovr_resp_data),
        .resp_noc0_ctovr_rdy  (resp_noc0_ctovr_rdy),
        .entry_val            (entry_val),
        .entry_data           (entry_data),
        .entry_last           (entry_last),
        .entry_rdy            (entry_rdy),
        .dump_done            (dump_done)
    );

    typedef struct {
        bit wrapped;
        int wr;
        bit stall;
        bit hold;
        int exp_n;
        int exp_first;
    } vec_t;

    localparam logic [7:0] T_META = 8'd20;
    localparam logic [7:0] T_RD   = 8'd21;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit stall, hold_start, want_start, resp_hold;
    bit cfg_wrapped;
    int cfg_wr;

    logic [63:0] rq_q[$];
    int          tg_q[$];
    int          rd_addrs[$];
    logic [31:0] ent_data[$];
    bit          ent_last[$];
    int n_meta, n_done, n_start, hs_err, fld_err, ovl_err;
    int last_evt, done_cyc;
    bit          p_req_pend, p_ent_pend, p_ent_last;
    logic [63:0] p_req_data;
    logic [31:0] p_ent_data;

    function automatic logic [31:0] mem_val(input int a);
        return 32'hE000_0000 + 32'(a) * 32'h0001_0111 + 32'd7;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_rec();
        rd_addrs.delete(); ent_data.delete(); ent_last.delete();
        n_meta = 0; n_done = 0; n_start = 0;
        hs_err = 0; fld_err = 0; ovl_err = 0;
        last_evt = -100; done_cyc = -1;
    endtask

    task automatic clear_env();
        rq_q.delete(); tg_q.delete();
        resp_hold = 0; p_req_pend = 0; p_ent_pend = 0;
        noc0_ctovr_resp_val = 0; noc0_ctovr_resp_data = '0;
    endtask

    task automatic env_cycle();
        logic [63:0] f;
        int a;
        @(negedge clk);
        cyc++;
        start_val = hold_start || want_start;
        noc0_vrtoc_req_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        entry_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rq_q.size() > 0) begin
            noc0_ctovr_resp_val = resp_hold ? 1'b1 :
                (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            noc0_ctovr_resp_data = rq_q[0];
        end else begin
            noc0_ctovr_resp_val  = 1'b0;
            noc0_ctovr_resp_data = '0;
        end
        #1;
        if (p_req_pend && (!req_noc0_vrtoc_val ||
            req_noc0_vrtoc_data !== p_req_data)) hs_err++;
        if (p_ent_pend && (!entry_val || entry_data !== p_ent_data ||
            entry_last !== p_ent_last)) hs_err++;
        if (resp_noc0_ctovr_rdy && rq_q.size() == 0) ovl_err++;
        if (dump_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (start_val && start_rdy) begin
            n_start++;
            want_start = 0;
        end
        if (noc0_ctovr_resp_val && resp_noc0_ctovr_rdy) begin
            if (tg_q[0] == 1) last_evt = cyc;
            void'(rq_q.pop_front());
            void'(tg_q.pop_front());
            resp_hold = 0;
        end else begin
            resp_hold = noc0_ctovr_resp_val;
        end
        if (req_noc0_vrtoc_val && noc0_vrtoc_req_rdy) begin
            f = req_noc0_vrtoc_data;
            if (rq_q.size() != 0) ovl_err++;
            if (f[63:32] !== 32'h0304_0102 || f[7:0] !== 8'h00)
                fld_err++;
            a = int'(f[23:8]);
            rq_q.push_back(64'hABCD_0000_0000_0000); tg_q.push_back(0);
            if (f[31:24] == T_META) begin
                n_meta++;
                if (a != 0) fld_err++;
                rq_q.push_back(64'hDEAD_BEEF_0000_0000 |
                               {59'h0, cfg_wrapped, 4'(cfg_wr)});
                tg_q.push_back(1);
            end else if (f[31:24] == T_RD) begin
                rd_addrs.push_back(a);
                rq_q.push_back({32'hBEEF_0000, mem_val(a)});
                tg_q.push_back(2);
            end else begin
                fld_err++;
                rq_q.push_back('0); tg_q.push_back(2);
            end
        end
        if (entry_val && entry_rdy) begin
            ent_data.push_back(entry_data);
            ent_last.push_back(entry_last);
            last_evt = cyc;
        end
        p_req_pend = req_noc0_vrtoc_val && !noc0_vrtoc_req_rdy;
        p_req_data = req_noc0_vrtoc_data;
        p_ent_pend = entry_val && !entry_rdy;
        p_ent_data = entry_data;
        p_ent_last = entry_last;
    endtask

    task automatic run_dump(input vec_t v, input string tg);
        int seq_err;
        int ea;
        clear_rec();
        cfg_wrapped = v.wrapped;
        cfg_wr      = v.wr;
        stall       = v.stall;
        hold_start  = v.hold;
        want_start  = 1;
        for (int k = 0; k < 3000 && n_done == 0; k++) env_cycle();
        chk({tg, ".finished"}, 64'(n_done > 0), 64'd1);
        hold_start = 0;
        for (int k = 0; k < 4; k++) env_cycle();
        chk({tg, ".n_done"}, 64'(n_done), 64'd1);
        chk({tg, ".n_meta"}, 64'(n_meta), 64'd1);
        chk({tg, ".n_start"}, 64'(n_start), 64'd1);
        chk({tg, ".n_reads"}, 64'(rd_addrs.size()), 64'(v.exp_n));
        chk({tg, ".n_entries"}, 64'(ent_data.size()), 64'(v.exp_n));
        seq_err = 0;
        for (int k = 0; k < v.exp_n && k < ent_data.size(); k++) begin
            ea = (v.exp_first + k) % 16;
            if (k < rd_addrs.size() && rd_addrs[k] != ea) seq_err++;
            if (ent_data[k] !== mem_val(ea)) seq_err++;
            if (ent_last[k] != (k == v.exp_n - 1)) seq_err++;
        end
        chk({tg, ".sequence_errs"}, 64'(seq_err), 64'd0);
        chk({tg, ".stability_errs"}, 64'(hs_err), 64'd0);
        chk({tg, ".flit_field_errs"}, 64'(fld_err), 64'd0);
        chk({tg, ".outstanding_errs"}, 64'(ovl_err), 64'd0);
        chk({tg, ".done_latency"}, 64'(done_cyc - last_evt), 64'd1);
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{0, 3, 0, 0, 3, 0};
        vt[1] = '{1, 14, 0, 0, 16, 14};
        vt[2] = '{0, 0, 0, 0, 0, 0};
        vt[3] = '{1, 14, 1, 0, 16, 14};
        vt[4] = '{0, 15, 1, 0, 15, 0};
        vt[5] = '{1, 0, 1, 0, 16, 0};
        vt[6] = '{0, 3, 0, 1, 3, 0};

        rst_n = 0; start_val = 0; stall = 0;
        hold_start = 0; want_start = 0;
        noc0_vrtoc_req_rdy = 0; entry_rdy = 0;
        clear_env();
        clear_rec();
        repeat (3) @(negedge clk);
        #1;
        chk("rst.start_rdy", 64'(start_rdy), 64'd1);
        chk("rst.req_val", 64'(req_noc0_vrtoc_val), 64'd0);
        chk("rst.req_data", req_noc0_vrtoc_data, 64'd0);
        chk("rst.resp_rdy", 64'(resp_noc0_ctovr_rdy), 64'd0);
        chk("rst.entry_val", 64'(entry_val), 64'd0);
        chk("rst.entry_last", 64'(entry_last), 64'd0);
        chk("rst.entry_data", 64'(entry_data), 64'd0);
        chk("rst.dump_done", 64'(dump_done), 64'd0);
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            run_dump(vt[i], $sformatf("vec%0d", i));
        end

        // Reset while the second of five entries is presented.
        clear_rec();
        cfg_wrapped = 0; cfg_wr = 5; stall = 0; want_start = 1;
        for (int k = 0; k < 500 && ent_data.size() < 2; k++)
            env_cycle();
        chk("mid.reached_entry2", 64'(ent_data.size()), 64'd2);
        rst_n = 0;
        @(negedge clk);
        #1;
        chk("mid.start_rdy", 64'(start_rdy), 64'd1);
        chk("mid.entry_val", 64'(entry_val), 64'd0);
        chk("mid.req_val", 64'(req_noc0_vrtoc_val), 64'd0);
        chk("mid.resp_rdy", 64'(resp_noc0_ctovr_rdy), 64'd0);
        chk("mid.dump_done", 64'(dump_done), 64'd0);
        chk("mid.entry_data", 64'(entry_data), 64'd0);
        rst_n = 1;
        clear_env();
        clear_rec();
        for (int k = 0; k < 5; k++) env_cycle();
        chk("mid.no_done_after_rst", 64'(n_done), 64'd0);
        chk("mid.no_req_after_rst", 64'(n_meta), 64'd0);
        run_dump('{0, 5, 0, 0, 5, 0}, "mid.redump");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
